// File: rtl/seg7_pkg.sv
// Shared constants and state encoding for the 7-segment display scheduler.
package seg7_pkg;

  localparam int NIB_W = 4;
  localparam int SEG_W = 7;

  // All segments off (the outputs are active-low).
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } sched_state_e;

endpackage

// File: rtl/seg_decoder.sv
// Hex nibble to active-low gfedcba segment pattern, full 0-F.
module seg_decoder
  import seg7_pkg::*;
(
  input  logic [NIB_W-1:0] nib_i,
  output logic [SEG_W-1:0] seg_o
);

  // Plain lookup; no state.
  always_comb begin
    seg_o = SEG_BLANK;
    unique case (nib_i)
      4'h0: seg_o = 7'h40;
      4'h1: seg_o = 7'h79;
      4'h2: seg_o = 7'h24;
      4'h3: seg_o = 7'h30;
      4'h4: seg_o = 7'h19;
      4'h5: seg_o = 7'h12;
      4'h6: seg_o = 7'h02;
      4'h7: seg_o = 7'h78;
      4'h8: seg_o = 7'h00;
      4'h9: seg_o = 7'h10;
      4'hA: seg_o = 7'h08;
      4'hB: seg_o = 7'h03;
      4'hC: seg_o = 7'h46;
      4'hD: seg_o = 7'h21;
      4'hE: seg_o = 7'h06;
      4'hF: seg_o = 7'h0E;
      default: seg_o = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/hex_display_scheduler.sv
// Walks a multi-digit 7-segment bank MSB-first through one shared decoder,
// one digit per clock, with masking, leading-zero suppression and a
// one-deep pending frame buffer.
module hex_display_scheduler
  import seg7_pkg::*;
#(
  parameter int NDIG = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [NIB_W*NDIG-1:0] data,
  input  logic [NDIG-1:0]       blank_mask,
  input  logic                  lzs,
  output logic                  busy,
  output logic                  done,
  output logic [SEG_W*NDIG-1:0] hex
);

  localparam int IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(NDIG - 1);

  sched_state_e                state_q, state_d;
  logic [IDX_W-1:0]            idx_q, idx_d;
  logic                        seen_q, seen_d;
  logic [NDIG-1:0][NIB_W-1:0]  frm_data_q, frm_data_d;
  logic [NDIG-1:0]             frm_mask_q, frm_mask_d;
  logic                        frm_lzs_q, frm_lzs_d;
  logic                        pnd_vld_q, pnd_vld_d;
  logic [NDIG-1:0][NIB_W-1:0]  pnd_data_q, pnd_data_d;
  logic [NDIG-1:0]             pnd_mask_q, pnd_mask_d;
  logic                        pnd_lzs_q, pnd_lzs_d;
  logic                        busy_q, done_q;

  logic [NIB_W-1:0] nib;
  logic [SEG_W-1:0] dec_seg, wr_seg;
  logic             cur_mask, wr_en;

  assign nib      = frm_data_q[idx_q];
  assign cur_mask = frm_mask_q[idx_q];
  assign wr_en    = (state_q == ST_SCAN);

  seg_decoder u_dec (
    .nib_i (nib),
    .seg_o (dec_seg)
  );

  // Final pattern for the digit under the scan pointer: mask, then zero
  // suppression; the rightmost digit always shows its value.
  always_comb begin
    wr_seg = dec_seg;
    if (cur_mask)
      wr_seg = SEG_BLANK;
    else if (frm_lzs_q && !seen_q && nib == '0 && idx_q != '0)
      wr_seg = SEG_BLANK;
  end

  // Next-state, frame promotion and pending capture.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    seen_d     = seen_q;
    frm_data_d = frm_data_q;
    frm_mask_d = frm_mask_q;
    frm_lzs_d  = frm_lzs_q;
    pnd_vld_d  = pnd_vld_q;
    pnd_data_d = pnd_data_q;
    pnd_mask_d = pnd_mask_q;
    pnd_lzs_d  = pnd_lzs_q;
    unique case (state_q)
      ST_IDLE: begin
        if (load) begin
          frm_data_d = data;
          frm_mask_d = blank_mask;
          frm_lzs_d  = lzs;
          idx_d      = IDX_TOP;
          seen_d     = 1'b0;
          state_d    = ST_SCAN;
        end
      end
      ST_SCAN: begin
        // Latest load during a scan wins the pending slot.
        if (load) begin
          pnd_vld_d  = 1'b1;
          pnd_data_d = data;
          pnd_mask_d = blank_mask;
          pnd_lzs_d  = lzs;
        end
        // A masked digit never ends suppression.
        seen_d = seen_q | (nib != '0 && !cur_mask);
        if (idx_q == '0) state_d = ST_DONE;
        else             idx_d   = idx_q - 1'b1;
      end
      ST_DONE: begin
        // A fresh load supersedes pending; pending is dropped either way.
        if (load) begin
          frm_data_d = data;
          frm_mask_d = blank_mask;
          frm_lzs_d  = lzs;
          pnd_vld_d  = 1'b0;
          idx_d      = IDX_TOP;
          seen_d     = 1'b0;
          state_d    = ST_SCAN;
        end else if (pnd_vld_q) begin
          frm_data_d = pnd_data_q;
          frm_mask_d = pnd_mask_q;
          frm_lzs_d  = pnd_lzs_q;
          pnd_vld_d  = 1'b0;
          idx_d      = IDX_TOP;
          seen_d     = 1'b0;
          state_d    = ST_SCAN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Control and frame registers; busy/done registered off next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      seen_q     <= 1'b0;
      frm_data_q <= '0;
      frm_mask_q <= '0;
      frm_lzs_q  <= 1'b0;
      pnd_vld_q  <= 1'b0;
      pnd_data_q <= '0;
      pnd_mask_q <= '0;
      pnd_lzs_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      seen_q     <= seen_d;
      frm_data_q <= frm_data_d;
      frm_mask_q <= frm_mask_d;
      frm_lzs_q  <= frm_lzs_d;
      pnd_vld_q  <= pnd_vld_d;
      pnd_data_q <= pnd_data_d;
      pnd_mask_q <= pnd_mask_d;
      pnd_lzs_q  <= pnd_lzs_d;
      busy_q     <= (state_d != ST_IDLE);
      done_q     <= (state_d == ST_DONE);
    end
  end

  assign busy = busy_q;
  assign done = done_q;

  // Per-digit output registers; only the digit under the pointer updates.
  for (genvar k = 0; k < NDIG; k++) begin : g_dig
    logic [SEG_W-1:0] seg_q;

    // Hold until this digit's scan slot comes round.
    always_ff @(posedge clk or posedge rst) begin
      if (rst)                                     seg_q <= SEG_BLANK;
      else if (wr_en && idx_q == IDX_W'(k))        seg_q <= wr_seg;
    end

    assign hex[SEG_W*k +: SEG_W] = seg_q;
  end

endmodule

// File: tb/tb_hex_display_scheduler.sv
// Directed bench for hex_display_scheduler at NDIG=6.
module tb_hex_display_scheduler;

  localparam int NDIG = 6;

  logic        clk = 1'b0;
  logic        rst;
  logic        load;
  logic [23:0] data;
  logic [5:0]  blank_mask;
  logic        lzs;
  logic        busy;
  logic        done;
  logic [41:0] hex;

  int checks = 0;
  int errors = 0;

  localparam logic [41:0] ALL_BLANK = {6{7'h7F}};

  hex_display_scheduler #(.NDIG(NDIG)) dut (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .data       (data),
    .blank_mask (blank_mask),
    .lzs        (lzs),
    .busy       (busy),
    .done       (done),
    .hex        (hex)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Load at cycle T (driven at its negedge), then watch cycles T+1..T+8.
  task automatic run_frame(input string tag, input logic [23:0] d, input logic [5:0] m,
                           input logic z, input logic [41:0] exp);
    int ndone;
    int dcyc;
    ndone = 0;
    dcyc  = 0;
    @(negedge clk);
    data = d; blank_mask = m; lzs = z; load = 1'b1;
    for (int c = 1; c <= NDIG + 2; c++) begin
      @(negedge clk);
      load = 1'b0;
      chk({tag, "_busy"}, 64'(busy), 64'(c <= NDIG + 1));
      if (done) begin ndone++; dcyc = c; end
      if (c == 2) chk({tag, "_msd"}, 64'(hex[41:35]), 64'(exp[41:35]));
    end
    chk({tag, "_ndone"}, 64'(ndone), 64'd1);
    chk({tag, "_dcyc"}, 64'(dcyc), 64'(NDIG + 1));
    chk({tag, "_hex"}, 64'(hex), 64'(exp));
  endtask

  initial begin
    int ndone;
    int d1;
    int d2;
    int busy_seen;
    logic [41:0] hex_a;
    rst = 1'b1; load = 1'b0; data = '0; blank_mask = '0; lzs = 1'b0;

    // Reset state, including a load held during reset.
    @(negedge clk);
    load = 1'b1; data = 24'h123456;
    @(negedge clk);
    chk("rst_hex", 64'(hex), 64'(ALL_BLANK));
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    load = 1'b0;
    rst = 1'b0;

    // Idle with no load: nothing moves.
    ndone = 0; busy_seen = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (done) ndone++;
      if (busy) busy_seen++;
    end
    chk("idle_done", 64'(ndone), 64'd0);
    chk("idle_busy", 64'(busy_seen), 64'd0);
    chk("idle_hex", 64'(hex), 64'(ALL_BLANK));

    // Plain decode, no suppression.
    run_frame("plain", 24'h12AB0F, 6'b000000, 1'b0,
              {7'h79, 7'h24, 7'h08, 7'h03, 7'h40, 7'h0E});
    // Zeros shown when suppression is off.
    run_frame("zeros_nolzs", 24'h000000, 6'b000000, 1'b0, {6{7'h40}});
    // Leading-zero suppression.
    run_frame("lzs", 24'h000450, 6'b000000, 1'b1,
              {7'h7F, 7'h7F, 7'h7F, 7'h19, 7'h12, 7'h40});
    run_frame("lzs_zero", 24'h000000, 6'b000000, 1'b1,
              {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40});
    // Masking combined with suppression.
    run_frame("mask", 24'h0000F3, 6'b100001, 1'b1,
              {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h0E, 7'h7F});
    // Masked nonzero MSD must not end suppression.
    run_frame("mask_nz", 24'h500020, 6'b100000, 1'b1,
              {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h24, 7'h40});

    // Pending buffer: A at T, B at T+2, C at T+4; B is overwritten.
    hex_a = {7'h79, 7'h24, 7'h08, 7'h03, 7'h40, 7'h0E};
    ndone = 0; d1 = 0; d2 = 0;
    @(negedge clk);
    data = 24'h12AB0F; blank_mask = '0; lzs = 1'b0; load = 1'b1;
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      load = 1'b0;
      if (c == 2) begin data = 24'h111111; load = 1'b1; end
      if (c == 4) begin data = 24'h654321; load = 1'b1; end
      if (done) begin
        ndone++;
        if (ndone == 1) d1 = c; else d2 = c;
      end
      if (c == 8)  chk("pend_a_hex", 64'(hex), 64'(hex_a));
      if (c == 15) chk("pend_busy_end", 64'(busy), 64'd0);
    end
    chk("pend_ndone", 64'(ndone), 64'd2);
    chk("pend_d1", 64'(d1), 64'd7);
    chk("pend_d2", 64'(d2), 64'd14);
    chk("pend_c_hex", 64'(hex),
        64'({7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79}));

    // Reset mid-scan with a pending frame queued.
    @(negedge clk);
    data = 24'h888888; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    @(negedge clk);
    data = 24'h777777; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    rst = 1'b1;
    #1;
    chk("mid_rst_hex", 64'(hex), 64'(ALL_BLANK));
    chk("mid_rst_busy", 64'(busy), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    busy_seen = 0; ndone = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (busy) busy_seen++;
      if (done) ndone++;
    end
    chk("post_rst_busy", 64'(busy_seen), 64'd0);
    chk("post_rst_done", 64'(ndone), 64'd0);
    chk("post_rst_hex", 64'(hex), 64'(ALL_BLANK));
    run_frame("post_rst", 24'hC0DE9A, 6'b000000, 1'b1,
              {7'h46, 7'h40, 7'h21, 7'h06, 7'h10, 7'h08});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
